// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data RAM on the CPU data-side bus, answering
// each accepted request with a one-cycle ready strobe after WAIT_CYCLES wait
// states. Keeps a saturating count of committed stores.
// Optional feature macro: DMEM_MMIO_DONE_EN adds a memory-mapped sticky "done"
// register at byte address DONE_ADDR (writes set done/done_data, reads return
// {31'b0, done}). Without it, done/done_data are tied to 0 and DONE_ADDR is
// an ordinary RAM location.
module dmem_responder #(
   parameter int          DEPTH_WORDS = 64,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] DONE_ADDR   = 32'd84
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic        memread,
   input  logic [31:0] dataaddr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        ready,
   output logic        err,
   output logic [15:0] store_count,
   output logic        done,
   output logic [31:0] done_data
);

   localparam int AW    = $clog2(DEPTH_WORDS);
   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT =
      (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             wr_q;
   logic             rd_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;

   logic [31:0] mem [DEPTH_WORDS];

   logic          req;
   logic          go_resp;
   logic          cur_wr;
   logic          cur_rd;
   logic [31:0]   cur_addr;
   logic [31:0]   cur_wdata;
   logic [AW-1:0] idx;
   logic          misalign;
   logic          out_of_range;
   logic          both;
   logic          done_hit;
   logic          acc_err;
   logic          ram_we;
   logic [31:0]   rd_word;

   assign req = memwrite | memread;

   // Select the live request in IDLE (needed for zero wait states) and the latched copy otherwise, then decode it
   always_comb begin
      cur_wr    = wr_q;
      cur_rd    = rd_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      if (state == S_IDLE) begin
         cur_wr    = memwrite;
         cur_rd    = memread;
         cur_addr  = dataaddr;
         cur_wdata = writedata;
      end
      go_resp = ((state == S_IDLE) && req && (WAIT_CYCLES == 0)) ||
                ((state == S_WAIT) && (cnt == '0));
      idx          = cur_addr[AW+1:2];
      misalign     = |cur_addr[1:0];
      out_of_range = |cur_addr[31:AW+2];
      both         = cur_wr & cur_rd;
      done_hit     = 1'b0;
`ifdef DMEM_MMIO_DONE_EN
      done_hit     = (cur_addr == DONE_ADDR) && !both;
`endif
      acc_err = misalign | both | (out_of_range & ~done_hit);
      ram_we  = go_resp & cur_wr & ~acc_err & ~done_hit;
      rd_word = mem[idx];
`ifdef DMEM_MMIO_DONE_EN
      if (done_hit) rd_word = {31'b0, done};
`endif
   end

   // RAM store at the edge entering RESP; suppressed while reset is asserted so an aborted write never lands
   always_ff @(posedge clk) begin
      if (reset && ram_we) mem[idx] <= cur_wdata;
   end

   // Handshake FSM with registered response outputs, store counter and done register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         wr_q        <= 1'b0;
         rd_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         ready       <= 1'b0;
         err         <= 1'b0;
         readdata    <= '0;
         store_count <= '0;
`ifdef DMEM_MMIO_DONE_EN
         done        <= 1'b0;
         done_data   <= '0;
`endif
      end else begin
         ready <= go_resp;
         err   <= go_resp & acc_err;
         case (state)
            S_IDLE: begin
               if (req) begin
                  wr_q    <= memwrite;
                  rd_q    <= memread;
                  addr_q  <= dataaddr;
                  wdata_q <= writedata;
                  if (WAIT_CYCLES == 0) begin
                     state <= S_RESP;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            S_WAIT: begin
               if (cnt == '0) state <= S_RESP;
               else           cnt   <= cnt - 1'b1;
            end
            default: state <= S_IDLE;
         endcase
         if (go_resp) begin
            if (acc_err)     readdata <= '0;
            else if (cur_rd) readdata <= rd_word;
            if (ram_we && (store_count != 16'hFFFF)) store_count <= store_count + 16'd1;
`ifdef DMEM_MMIO_DONE_EN
            if (cur_wr && done_hit && !acc_err) begin
               done      <= 1'b1;
               done_data <= cur_wdata;
            end
`endif
         end
      end
   end

`ifndef DMEM_MMIO_DONE_EN
   assign done      = 1'b0;
   assign done_data = '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with WAIT_CYCLES=2 (index 0)
// and one with WAIT_CYCLES=0 (index 1), sharing clock and reset.
module tb_dmem_responder;

   logic        clk;
   logic        reset;
   logic        mw  [2];
   logic        mr  [2];
   logic [31:0] ad  [2];
   logic [31:0] wd  [2];
   logic [31:0] rdt [2];
   logic        rdy [2];
   logic        er  [2];
   logic [15:0] sc  [2];
   logic        dn  [2];
   logic [31:0] dd  [2];

   int total = 0;
   int bad   = 0;

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2), .DONE_ADDR(32'd84)) u_w2 (
      .clk(clk), .reset(reset), .memwrite(mw[0]), .memread(mr[0]),
      .dataaddr(ad[0]), .writedata(wd[0]), .readdata(rdt[0]), .ready(rdy[0]),
      .err(er[0]), .store_count(sc[0]), .done(dn[0]), .done_data(dd[0]));

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0), .DONE_ADDR(32'd84)) u_w0 (
      .clk(clk), .reset(reset), .memwrite(mw[1]), .memread(mr[1]),
      .dataaddr(ad[1]), .writedata(wd[1]), .readdata(rdt[1]), .ready(rdy[1]),
      .err(er[1]), .store_count(sc[1]), .done(dn[1]), .done_data(dd[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One access on instance d; returns data/err at ready and the cycle count from acceptance edge (1 = acceptance edge)
   task automatic acc(input int d, input logic w, input logic r, input logic [31:0] a,
                      input logic [31:0] wdat, output logic [31:0] rdo, output logic eo,
                      output int lat);
      @(negedge clk);
      mw[d] = w; mr[d] = r; ad[d] = a; wd[d] = wdat;
      lat = 0; rdo = '0; eo = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (rdy[d]) begin
            lat = i; rdo = rdt[d]; eo = er[d];
            break;
         end
      end
      @(negedge clk);
      mw[d] = 1'b0; mr[d] = 1'b0;
      if (lat == 0) check("ready_timeout", 32'(lat), 32'd1);
      @(posedge clk); #1;
      check("ready_one_cycle", 32'(rdy[d]), 32'd0);
   endtask

   logic [31:0] rd;
   logic        e;
   int          lat;
   int          seen;
   logic [15:0] sc_exp;

   initial begin
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         mw[k] = 1'b0; mr[k] = 1'b0; ad[k] = '0; wd[k] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(rdy[0]), 32'd0);
      check("rst_err", 32'(er[0]), 32'd0);
      check("rst_readdata", rdt[0], 32'd0);
      check("rst_store_count", 32'(sc[0]), 32'd0);
      check("rst_done", 32'(dn[0]), 32'd0);
      check("rst_done_data", dd[0], 32'd0);
      check("rst_ready_w0", 32'(rdy[1]), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      seen = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (rdy[0] || rdy[1]) seen = 1;
      end
      check("idle_no_ready", 32'(seen), 32'd0);

      // WAIT_CYCLES=2: write 80=7, then read it back
      acc(0, 1'b1, 1'b0, 32'd80, 32'd7, rd, e, lat);
      check("w2_wr_lat", 32'(lat), 32'd3);
      check("w2_wr_err", 32'(e), 32'd0);
      check("w2_wr_count", 32'(sc[0]), 32'd1);
      sc_exp = 16'd1;
      acc(0, 1'b0, 1'b1, 32'd80, 32'd0, rd, e, lat);
      check("w2_rd_lat", 32'(lat), 32'd3);
      check("w2_rd_data", rd, 32'd7);
      check("w2_rd_err", 32'(e), 32'd0);

      // WAIT_CYCLES=0: back-to-back writes and reads
      acc(1, 1'b1, 1'b0, 32'd0, 32'd5, rd, e, lat);
      check("w0_wr0_lat", 32'(lat), 32'd1);
      acc(1, 1'b1, 1'b0, 32'd4, 32'd6, rd, e, lat);
      check("w0_wr4_lat", 32'(lat), 32'd1);
      acc(1, 1'b0, 1'b1, 32'd0, 32'd0, rd, e, lat);
      check("w0_rd0_lat", 32'(lat), 32'd1);
      check("w0_rd0_data", rd, 32'd5);
      acc(1, 1'b0, 1'b1, 32'd4, 32'd0, rd, e, lat);
      check("w0_rd4_data", rd, 32'd6);
      check("w0_count", 32'(sc[1]), 32'd2);

      // Error cases on the WAIT_CYCLES=2 instance
      acc(0, 1'b1, 1'b0, 32'd82, 32'd11, rd, e, lat);
      check("err_misalign", 32'(e), 32'd1);
      check("err_misalign_lat", 32'(lat), 32'd3);
      acc(0, 1'b1, 1'b0, 32'd256, 32'd12, rd, e, lat);
      check("err_range", 32'(e), 32'd1);
      acc(0, 1'b1, 1'b1, 32'd80, 32'd13, rd, e, lat);
      check("err_both", 32'(e), 32'd1);
      check("err_count", 32'(sc[0]), 32'(sc_exp));
      acc(0, 1'b0, 1'b1, 32'd300, 32'd0, rd, e, lat);
      check("err_rd_range", 32'(e), 32'd1);
      check("err_rd_data", rd, 32'd0);
      acc(0, 1'b0, 1'b1, 32'd80, 32'd0, rd, e, lat);
      check("after_err_rd80", rd, 32'd7);
      check("after_err_rd80_err", 32'(e), 32'd0);

      // Done address write/read
      acc(0, 1'b1, 1'b0, 32'd84, 32'd7, rd, e, lat);
      check("done_wr_err", 32'(e), 32'd0);
      check("done_wr_lat", 32'(lat), 32'd3);
`ifdef DMEM_MMIO_DONE_EN
      check("done_flag", 32'(dn[0]), 32'd1);
      check("done_data", dd[0], 32'd7);
      check("done_count", 32'(sc[0]), 32'(sc_exp));
      acc(0, 1'b0, 1'b1, 32'd84, 32'd0, rd, e, lat);
      check("done_rd", rd, 32'd1);
`else
      sc_exp = sc_exp + 16'd1;
      check("done_flag", 32'(dn[0]), 32'd0);
      check("done_data", dd[0], 32'd0);
      check("done_count", 32'(sc[0]), 32'(sc_exp));
      acc(0, 1'b0, 1'b1, 32'd84, 32'd0, rd, e, lat);
      check("done_rd", rd, 32'd7);
`endif

      // Completed write, then a write aborted by reset during WAIT
      acc(0, 1'b1, 1'b0, 32'd88, 32'd3, rd, e, lat);
      sc_exp = sc_exp + 16'd1;
      check("wr88_count", 32'(sc[0]), 32'(sc_exp));
      @(negedge clk);
      mw[0] = 1'b1; ad[0] = 32'd88; wd[0] = 32'd9;
      @(posedge clk); #1;
      #2;
      reset = 1'b0;
      mw[0] = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      seen = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (rdy[0]) seen = 1;
      end
      check("abort_no_ready", 32'(seen), 32'd0);
      check("abort_count", 32'(sc[0]), 32'd0);
      check("abort_done", 32'(dn[0]), 32'd0);
      acc(0, 1'b0, 1'b1, 32'd88, 32'd0, rd, e, lat);
      check("abort_rd88", rd, 32'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the CPU's data-side bus (memwrite, memread, dataaddr, writedata); it is the slave end of the accesses the CPU core initiates.
- Word-addressed RAM behind a request/ready handshake with configurable wait states; replaces the zero-latency memory model so cores and benches exercise stalled memory.
- Also exposes a store counter and an optional memory-mapped "done" register for self-checking simulation.

Parameters:
DEPTH_WORDS, 64, RAM size in 32-bit words; power of two, minimum 4.
WAIT_CYCLES, 2, wait states between acceptance and response; 0 allowed.
DONE_ADDR, 84, byte address of the done register; only used with MMIO_DONE_EN.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset; asserted when 0.
memwrite  in  1  write request.
memread  in  1  read request.
dataaddr  in  32  byte address of the access.
writedata  in  32  store data.
readdata  out  32  load data; valid while ready=1 for a read.
ready  out  1  one-cycle response strobe.
err  out  1  access error; valid only while ready=1.
store_count  out  16  number of committed RAM stores, saturating.
done  out  1  sticky done flag (MMIO_DONE_EN only).
done_data  out  32  data captured with done (MMIO_DONE_EN only).

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; ready=0, err=0, readdata=0, store_count=0, done=0, done_data=0. RAM contents are not reset.
- FSM states:
  - IDLE: if memwrite|memread at a rising edge, latch address, data and type (edge N). Go to WAIT with cnt=WAIT_CYCLES-1, or directly to RESP if WAIT_CYCLES=0.
  - WAIT: cnt decrements each edge; at the edge where cnt=0, go to RESP.
  - RESP: ready=1 for exactly this cycle; next edge returns unconditionally to IDLE.
- Latency: ready is high during the cycle after edge N+WAIT_CYCLES. Throughput is one access per WAIT_CYCLES+2 cycles.
- Request inputs are ignored after acceptance; the latched copy is used. The requester must hold its request until it sees ready.
- Decode: word index = dataaddr[log2(DEPTH_WORDS)+1:2].
  - err=1 if dataaddr[1:0]!=0, dataaddr >= 4*DEPTH_WORDS, or memwrite and memread were both high at acceptance.
  - On err: no RAM write, readdata=0, store_count unchanged.
- Write:
  - RAM updated at the edge entering RESP.
  - store_count increments at the same edge and saturates at 16'hFFFF.
  - readdata holds its previous value.
- Read: readdata loaded at the edge entering RESP and held until the next read response or reset.
- Reset mid-operation: FSM returns to IDLE immediately, the pending write is discarded, and no ready is issued.

Optional Feature:
- Macro: DMEM_MMIO_DONE_EN.
- Defined:
  - A write whose latched dataaddr equals DONE_ADDR (aligned) bypasses the RAM and range check.
  - At the edge entering RESP: done<=1 (sticky until reset) and done_data<=writedata; ready pulses with err=0; store_count does not increment.
  - A read of DONE_ADDR returns {31'b0, done}.
- Undefined: done and done_data are tied to 0, and DONE_ADDR is an ordinary RAM address.

Test Plan:
- Hold reset=0 for 2 cycles -> ready=0, err=0, readdata=0, store_count=0, done=0. Release, then idle 5 cycles -> ready remains 0.
- WAIT_CYCLES=2: write addr 80 data 7 accepted at edge N -> ready=1, err=0 only in the cycle after edge N+2; store_count=1. Read addr 80 -> readdata=32'd7 with ready.
- WAIT_CYCLES=0: back-to-back writes addr 0 = 5 and addr 4 = 6, then reads of both -> each ready exactly 1 cycle after its acceptance edge; reads return 5 and 6; store_count=2.
- Write addr 82 (misaligned) and addr 256 (DEPTH_WORDS=64) -> err=1 with ready for each; store_count unchanged; read addr 80 still returns 7.
- Write addr 88 = 3 completes. Write addr 88 = 9 with reset pulsed low during WAIT -> no ready for the aborted write; store_count=0 after reset; read addr 88 returns 3.
- DMEM_MMIO_DONE_EN defined: write addr 84 data 7 -> ready, err=0, done=1, done_data=7, store_count unchanged; read addr 84 -> readdata=1. Without the macro, the same write stores to RAM and done stays 0.
